// File: rtl/nios2_seq_div_cell.sv
// nios2_seq_div_cell: iterative radix-2 restoring divider with valid/ready operand and result handshakes
module nios2_seq_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div0
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] a_q, b_q, mag_d, mag_b;
  logic [DATA_W:0] rem_p, shifted, diff;
  logic [CW-1:0] cnt;
  logic sgn_q, q_neg, r_neg, dz;
  assign in_ready = state == IDLE;
  assign shifted = {rem_p[DATA_W-1:0], mag_d[DATA_W-1]};
  assign diff = shifted - {1'b0, mag_b};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? PREP : IDLE;
      PREP: state_nx = ITER;
      ITER: state_nx = cnt == '0 ? FIX : ITER;
      FIX:  state_nx = DONE;
      DONE: state_nx = result_valid && result_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs load one cycle into DONE so the result register is the only thing the consumer sees
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      mag_d <= '0;
      mag_b <= '0;
      rem_p <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div0 <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= dividend;
          b_q <= divisor;
          sgn_q <= in_signed;
        end
        PREP: begin
          mag_d <= sgn_q && a_q[DATA_W-1] ? -a_q : a_q;
          mag_b <= sgn_q && b_q[DATA_W-1] ? -b_q : b_q;
          q_neg <= sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          r_neg <= sgn_q & a_q[DATA_W-1];
          dz <= b_q == '0;
          cnt <= CW'(DATA_W - 1);
          rem_p <= '0;
        end
        ITER: begin
          rem_p <= diff[DATA_W] ? shifted : diff;
          mag_d <= {mag_d[DATA_W-2:0], ~diff[DATA_W]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          mag_d <= dz ? '1 : q_neg ? -mag_d : mag_d;
          rem_p <= {1'b0, dz ? a_q : r_neg ? -rem_p[DATA_W-1:0] : rem_p[DATA_W-1:0]};
        end
        DONE: if (!result_valid) begin
          quotient <= mag_d;
          remainder <= rem_p[DATA_W-1:0];
          div0 <= dz;
          result_valid <= 1'b1;
        end else if (result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_nios2_seq_div_cell.sv
// tb_nios2_seq_div_cell: directed self-checking bench for the sequential divider
module tb_nios2_seq_div_cell;
  logic clk = 0, reset = 1, in_valid = 0, in_signed = 0, result_ready = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic in_ready, result_valid, div0;
  logic [31:0] quotient, remainder;
  int errors = 0, checks = 0;

  nios2_seq_div_cell #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
    .result_valid(result_valid), .result_ready(result_ready),
    .quotient(quotient), .remainder(remainder), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    in_valid = 1; dividend = a; divisor = b; in_signed = s;
    @(posedge clk);
    #1;
    in_valid = 0; dividend = 32'hDEAD_BEEF; divisor = 32'h0; in_signed = ~s;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!result_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    result_ready = 1;
    @(posedge clk);
    #1;
    result_ready = 0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic d, output int lat);
    start_op(a, b, s);
    wait_result(lat);
    q = quotient; r = remainder; d = div0;
    handshake();
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({in_ready, result_valid, quotient, remainder, div0} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h d=%b want rdy=1 vld=0 q=0 r=0 d=0",
               in_ready, result_valid, quotient, remainder, div0);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_unsigned;
    logic [31:0] q, r; logic d; int lat;
    run_op(32'd100, 32'd7, 1'b0, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'd14, 32'd2, 1'b0}) begin
      errors++; $display("FAIL u100_7 got q=%h r=%h d=%b want q=e r=2 d=0", q, r, d);
    end
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL u100_7_latency got %0d want 35", lat); end
    checks++;
    if ({result_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL post_handshake got vld=%b rdy=%b want vld=0 rdy=1", result_valid, in_ready);
    end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'hFFFF_FFFF, 32'h0, 1'b0}) begin
      errors++; $display("FAIL uffff_1 got q=%h r=%h d=%b want q=ffffffff r=0 d=0", q, r, d);
    end
  endtask

  task automatic test_signed;
    logic [31:0] q, r; logic d; int lat;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
      errors++; $display("FAIL s_m7_2 got q=%h r=%h d=%b want q=fffffffd r=ffffffff d=0", q, r, d);
    end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'hFFFF_FFFD, 32'd1, 1'b0}) begin
      errors++; $display("FAIL s_7_m2 got q=%h r=%h d=%b want q=fffffffd r=1 d=0", q, r, d);
    end
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'h7FFF_FFFC, 32'd1, 1'b0}) begin
      errors++; $display("FAIL u_fff9_2 got q=%h r=%h d=%b want q=7ffffffc r=1 d=0", q, r, d);
    end
  endtask

  task automatic test_div0;
    logic [31:0] q, r; logic d; int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(32'd12345, 32'd0, s[0], q, r, d, lat);
      checks++;
      if ({q, r, d} !== {32'hFFFF_FFFF, 32'd12345, 1'b1}) begin
        errors++; $display("FAIL div0_s%0d got q=%h r=%h d=%b want q=ffffffff r=3039 d=1", s, q, r, d);
      end
      checks++;
      if (lat !== 35) begin errors++; $display("FAIL div0_s%0d_latency got %0d want 35", s, lat); end
    end
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1}) begin
      errors++; $display("FAIL div0_neg got q=%h r=%h d=%b want q=ffffffff r=fffffff9 d=1", q, r, d);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] q, r; logic d; int lat;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'h8000_0000, 32'h0, 1'b0}) begin
      errors++; $display("FAIL s_ovf got q=%h r=%h d=%b want q=80000000 r=0 d=0", q, r, d);
    end
    run_op(32'h8000_0000, 32'd3, 1'b1, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'hD555_5556, 32'hFFFF_FFFE, 1'b0}) begin
      errors++; $display("FAIL s_min_3 got q=%h r=%h d=%b want q=d5555556 r=fffffffe d=0", q, r, d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r, q0, r0; logic d, d0; int lat, bad;
    start_op(32'd77, 32'd10, 1'b0);
    wait_result(lat);
    q0 = quotient; r0 = remainder; d0 = div0; bad = 0;
    checks++;
    if ({q0, r0, d0} !== {32'd7, 32'd7, 1'b0}) begin
      errors++; $display("FAIL bp_first got q=%h r=%h d=%b want q=7 r=7 d=0", q0, r0, d0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i == 3; dividend = 32'd55; divisor = 32'd5; in_signed = 0;
      @(posedge clk);
      #1;
      if (!result_valid || in_ready || {quotient, remainder, div0} !== {q0, r0, d0}) bad++;
    end
    in_valid = 0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    handshake();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, result_valid, quotient} !== {1'b1, 1'b0, 32'd7}) begin
      errors++; $display("FAIL bp_no_accept got rdy=%b vld=%b q=%h want rdy=1 vld=0 q=7", in_ready, result_valid, quotient);
    end
    run_op(32'd1000, 32'd33, 1'b0, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'd30, 32'd10, 1'b0} || lat !== 35) begin
      errors++; $display("FAIL bp_next got q=%h r=%h d=%b lat=%0d want q=1e r=a d=0 lat=35", q, r, d, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r; logic d; int lat;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    reset = 1;
    #1;
    checks++;
    if ({in_ready, result_valid, quotient, remainder, div0} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b q=%h r=%h d=%b want rdy=1 vld=0 q=0 r=0 d=0",
               in_ready, result_valid, quotient, remainder, div0);
    end
    @(negedge clk);
    reset = 0;
    run_op(32'd9, 32'd3, 1'b0, q, r, d, lat);
    checks++;
    if ({q, r, d} !== {32'd3, 32'd0, 1'b0} || lat !== 35) begin
      errors++; $display("FAIL after_reset got q=%h r=%h d=%b lat=%0d want q=3 r=0 d=0 lat=35", q, r, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div0();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
